decode_stage_pipe: RTL and testbench

Parametrised decode stage that sits between fetch and the ALU stage. It accepts instruction words over a valid/ready handshake and reads operands from an internal register file that has one write-back port. It generates control bits, assembles two-word load-immediate instructions, detects load-use hazards, and presents one registered decode bundle to the execute stage under downstream backpressure.

---
 rtl/decode_stage_pipe.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_pipe
// Summary  : Decode stage with register file, LDI assembly, LD-use stall and
//            a registered output bundle. Define DECODE_BYPASS_EN to forward a
//            same-cycle write-back into operand reads.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_instr,
    output logic              in_ready,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_AW-1:0] out_rd,
    output logic [1:0]        out_alu_op,
    output logic              out_use_imm,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_wb
);

    localparam int NREG = 2**REG_AW;
    localparam int HW   = 3 + 2*REG_AW;

    localparam logic [2:0] c_op_add = 3'b001;
    localparam logic [2:0] c_op_sub = 3'b010;
    localparam logic [2:0] c_op_and = 3'b011;
    localparam logic [2:0] c_op_or  = 3'b100;
    localparam logic [2:0] c_op_ldi = 3'b101;
    localparam logic [2:0] c_op_ld  = 3'b110;
    localparam logic [2:0] c_op_st  = 3'b111;

    typedef enum logic [1:0] {
        ST_DEC   = 2'd0,
        ST_IMM   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rf_q [NREG];
    logic [HW-1:0]     held_q, held_d;
    logic [REG_AW-1:0] ldi_rd_q, ldi_rd_d;
    logic              sb_valid_q, sb_valid_d;
    logic [REG_AW-1:0] sb_rd_q, sb_rd_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_op1_q, out_op1_d;
    logic [DATA_W-1:0] out_op2_q, out_op2_d;
    logic [DATA_W-1:0] out_imm_q, out_imm_d;
    logic [REG_AW-1:0] out_rd_q, out_rd_d;
    logic [1:0]        out_alu_op_q, out_alu_op_d;
    logic              out_use_imm_q, out_use_imm_d;
    logic              out_mem_read_q, out_mem_read_d;
    logic              out_mem_write_q, out_mem_write_d;
    logic              out_wb_q, out_wb_d;

    logic              out_free;
    logic              accept;
    logic [HW-1:0]     dec_word;
    logic [2:0]        opc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [DATA_W-1:0] rd1_val;
    logic [DATA_W-1:0] rd2_val;
    logic              reads_rs1;
    logic              reads_rs2;
    logic              hazard;
    logic              issue_dec;
    logic              issue_ldi;

    logic [1:0]        b_alu_op;
    logic              b_mem_read;
    logic              b_mem_write;
    logic              b_wb;
    logic [DATA_W-1:0] b_op1;
    logic [DATA_W-1:0] b_op2;

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = reset && (state_q != ST_STALL) && out_free;
    assign accept   = in_valid && in_ready;

    // A stalled instruction is re-decoded from the held copy, not from fetch.
    assign dec_word = (state_q == ST_STALL) ? held_q : in_instr[DATA_W-1 -: HW];
    assign opc      = dec_word[HW-1 -: 3];
    assign rs1      = dec_word[2*REG_AW-1 -: REG_AW];
    assign rs2      = dec_word[REG_AW-1:0];

    always_comb begin
        rd1_val = rf_q[rs1];
        rd2_val = rf_q[rs2];
`ifdef DECODE_BYPASS_EN
        if (wb_en && (wb_addr == rs1)) rd1_val = wb_data;
        if (wb_en && (wb_addr == rs2)) rd2_val = wb_data;
`endif
    end

    always_comb begin
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        case (opc)
            c_op_add, c_op_sub, c_op_and, c_op_or, c_op_st: begin
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
            end
            c_op_ld:  reads_rs2 = 1'b1;
            default:  ;
        endcase
    end

    assign hazard = sb_valid_q && ((reads_rs1 && (rs1 == sb_rd_q)) ||
                                   (reads_rs2 && (rs2 == sb_rd_q)));

    always_comb begin
        b_alu_op    = 2'b00;
        b_mem_read  = 1'b0;
        b_mem_write = 1'b0;
        b_wb        = 1'b0;
        b_op1       = rd1_val;
        b_op2       = rd2_val;
        case (opc)
            c_op_add: b_wb = 1'b1;
            c_op_sub: begin b_alu_op = 2'b01; b_wb = 1'b1; end
            c_op_and: begin b_alu_op = 2'b10; b_wb = 1'b1; end
            c_op_or:  begin b_alu_op = 2'b11; b_wb = 1'b1; end
            c_op_ld: begin
                b_mem_read = 1'b1;
                b_wb       = 1'b1;
                b_op1      = rd2_val;
            end
            c_op_st: begin
                b_mem_write = 1'b1;
                b_op1       = rd2_val;
                b_op2       = rd1_val;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        held_d          = held_q;
        ldi_rd_d        = ldi_rd_q;
        sb_valid_d      = sb_valid_q;
        sb_rd_d         = sb_rd_q;
        issue_dec       = 1'b0;
        issue_ldi       = 1'b0;
        out_valid_d     = out_valid_q;
        out_op1_d       = out_op1_q;
        out_op2_d       = out_op2_q;
        out_imm_d       = out_imm_q;
        out_rd_d        = out_rd_q;
        out_alu_op_d    = out_alu_op_q;
        out_use_imm_d   = out_use_imm_q;
        out_mem_read_d  = out_mem_read_q;
        out_mem_write_d = out_mem_write_q;
        out_wb_d        = out_wb_q;

        case (state_q)
            ST_DEC: begin
                if (accept) begin
                    if (opc == c_op_ldi) begin
                        ldi_rd_d = rs1;
                        state_d  = ST_IMM;
                    end else if (hazard) begin
                        held_d  = dec_word;
                        state_d = ST_STALL;
                    end else begin
                        issue_dec = 1'b1;
                    end
                end
            end
            ST_IMM: begin
                if (accept) begin
                    issue_ldi = 1'b1;
                    state_d   = ST_DEC;
                end
            end
            ST_STALL: begin
                if (out_free) begin
                    issue_dec = 1'b1;
                    state_d   = ST_DEC;
                end
            end
            default: state_d = ST_DEC;
        endcase

        if (out_free) out_valid_d = issue_dec || issue_ldi;

        if (issue_dec) begin
            out_op1_d       = b_op1;
            out_op2_d       = b_op2;
            out_imm_d       = '0;
            out_rd_d        = rs1;
            out_alu_op_d    = b_alu_op;
            out_use_imm_d   = 1'b0;
            out_mem_read_d  = b_mem_read;
            out_mem_write_d = b_mem_write;
            out_wb_d        = b_wb;
            sb_valid_d      = (opc == c_op_ld);
            sb_rd_d         = rs1;
        end else if (issue_ldi) begin
            out_op1_d       = '0;
            out_op2_d       = '0;
            out_imm_d       = in_instr;
            out_rd_d        = ldi_rd_q;
            out_alu_op_d    = 2'b00;
            out_use_imm_d   = 1'b1;
            out_mem_read_d  = 1'b0;
            out_mem_write_d = 1'b0;
            out_wb_d        = 1'b1;
            sb_valid_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_en) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_DEC;
            held_q          <= '0;
            ldi_rd_q        <= '0;
            sb_valid_q      <= 1'b0;
            sb_rd_q         <= '0;
            out_valid_q     <= 1'b0;
            out_op1_q       <= '0;
            out_op2_q       <= '0;
            out_imm_q       <= '0;
            out_rd_q        <= '0;
            out_alu_op_q    <= 2'b00;
            out_use_imm_q   <= 1'b0;
            out_mem_read_q  <= 1'b0;
            out_mem_write_q <= 1'b0;
            out_wb_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            held_q          <= held_d;
            ldi_rd_q        <= ldi_rd_d;
            sb_valid_q      <= sb_valid_d;
            sb_rd_q         <= sb_rd_d;
            out_valid_q     <= out_valid_d;
            out_op1_q       <= out_op1_d;
            out_op2_q       <= out_op2_d;
            out_imm_q       <= out_imm_d;
            out_rd_q        <= out_rd_d;
            out_alu_op_q    <= out_alu_op_d;
            out_use_imm_q   <= out_use_imm_d;
            out_mem_read_q  <= out_mem_read_d;
            out_mem_write_q <= out_mem_write_d;
            out_wb_q        <= out_wb_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_op1       = out_op1_q;
    assign out_op2       = out_op2_q;
    assign out_imm       = out_imm_q;
    assign out_rd        = out_rd_q;
    assign out_alu_op    = out_alu_op_q;
    assign out_use_imm   = out_use_imm_q;
    assign out_mem_read  = out_mem_read_q;
    assign out_mem_write = out_mem_write_q;
    assign out_wb        = out_wb_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage_pipe
// Summary  : Directed plus randomized bench for decode_stage_pipe against a
//            transaction-level model; honours DECODE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_op1, out_op2, out_imm;
    logic [2:0]  out_rd;
    logic [1:0]  out_alu_op;
    logic        out_use_imm, out_mem_read, out_mem_write, out_wb;

    int tests = 0;
    int fails = 0;

    decode_stage_pipe #(.DATA_W(16), .REG_AW(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
        .out_rd(out_rd), .out_alu_op(out_alu_op), .out_use_imm(out_use_imm),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_wb(out_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (transaction level) ----------------
    bit          e_valid, e_ui, e_mr, e_mw, e_wb, e_c1, e_c2;
    logic [15:0] e_op1, e_op2, e_imm;
    logic [2:0]  e_rd;
    logic [1:0]  e_alu;
    logic [15:0] m_rf [8];
    int          m_mode;      // 0 expecting instruction, 1 expecting immediate, 2 stalled
    logic [15:0] m_held;
    logic [2:0]  m_ldi_rd;
    bit          m_ld_live;
    logic [2:0]  m_ld_rd;
    bit          m_free;

    function automatic logic [15:0] rdreg(input logic [2:0] a);
`ifdef DECODE_BYPASS_EN
        if (wb_en && wb_addr == a) return wb_data;
`endif
        return m_rf[a];
    endfunction

    function automatic bit hz(input logic [15:0] w);
        if (!m_ld_live) return 1'b0;
        case (w[15:13])
            3'd1, 3'd2, 3'd3, 3'd4, 3'd7: return (w[12:10] == m_ld_rd) || (w[9:7] == m_ld_rd);
            3'd6:                         return w[9:7] == m_ld_rd;
            default:                      return 1'b0;
        endcase
    endfunction

    task automatic clear_bundle();
        e_imm = 0; e_ui = 0; e_mr = 0; e_mw = 0; e_wb = 0; e_alu = 0;
        e_c1 = 0; e_c2 = 0; e_op1 = 0; e_op2 = 0;
    endtask

    task automatic issue_word(input logic [15:0] w);
        logic [2:0] op;
        op = w[15:13];
        clear_bundle();
        e_valid = 1; e_rd = w[12:10];
        if (op >= 3'd1 && op <= 3'd4) begin
            e_alu = 2'(op - 3'd1); e_wb = 1;
            e_op1 = rdreg(w[12:10]); e_op2 = rdreg(w[9:7]); e_c1 = 1; e_c2 = 1;
        end else if (op == 3'd6) begin
            e_mr = 1; e_wb = 1; e_op1 = rdreg(w[9:7]); e_c1 = 1;
        end else if (op == 3'd7) begin
            e_mw = 1; e_op1 = rdreg(w[9:7]); e_op2 = rdreg(w[12:10]); e_c1 = 1; e_c2 = 1;
        end
        m_ld_live = (op == 3'd6);
        m_ld_rd   = w[12:10];
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                e_valid = 0; m_mode = 0; m_ld_live = 0; clear_bundle(); e_rd = 0;
                for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
            end else begin
                m_free = !e_valid || out_ready;
                if (m_free) begin
                    e_valid = 0;
                    if (m_mode == 2) begin
                        issue_word(m_held);
                        m_mode = 0;
                    end else if (in_valid) begin
                        if (m_mode == 1) begin
                            clear_bundle();
                            e_valid = 1; e_rd = m_ldi_rd; e_imm = in_instr;
                            e_ui = 1; e_wb = 1; m_ld_live = 0; m_mode = 0;
                        end else if (in_instr[15:13] == 3'd5) begin
                            m_ldi_rd = in_instr[12:10]; m_mode = 1;
                        end else if (hz(in_instr)) begin
                            m_held = in_instr; m_mode = 2;
                        end else begin
                            issue_word(in_instr);
                        end
                    end
                end
                if (wb_en) m_rf[wb_addr] = wb_data;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_in_ready", in_ready, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_outs", {out_op1, out_op2}, 0);
                chk("rst_imm_ctl", {out_imm, out_rd, out_alu_op, out_use_imm,
                                    out_mem_read, out_mem_write, out_wb}, 0);
            end else begin
                chk("in_ready", in_ready, (m_mode != 2) && (!e_valid || out_ready));
                chk("out_valid", out_valid, e_valid);
                if (e_valid) begin
                    chk("rd", out_rd, e_rd);
                    chk("ctl", {out_alu_op, out_use_imm, out_mem_read, out_mem_write, out_wb},
                               {e_alu, e_ui, e_mr, e_mw, e_wb});
                    chk("imm", out_imm, e_imm);
                    if (e_c1) chk("op1", out_op1, e_op1);
                    if (e_c2) chk("op2", out_op2, e_op2);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [15:0] w);
        int n;
        n = 0;
        in_valid = 1; in_instr = w;
        @(negedge clk);
        while (!in_ready && n < 40) begin n++; @(negedge clk); end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 40 cycles");
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    localparam logic [15:0] W_ADD_3_4 = 16'h2E00;
    localparam logic [15:0] W_LDI_2   = 16'hA800;
    localparam logic [15:0] W_LD_5_3  = 16'hD580;
    localparam logic [15:0] W_SUB_5_4 = 16'h5600;
    localparam logic [15:0] W_AND_1_2 = 16'h6500;
    localparam logic [15:0] W_OR_1_2  = 16'h8500;

    initial begin
        reset = 0; in_valid = 0; in_instr = 0; out_ready = 1;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;

        wb_en = 1; wb_addr = 3; wb_data = 16'h0012; cyc();
        wb_addr = 4; wb_data = 16'h0005; cyc();
        wb_en = 0;
        send(W_ADD_3_4);
        @(negedge clk);
        chk("add_valid", out_valid, 1);
        chk("add_op1", out_op1, 16'h0012);
        chk("add_op2", out_op2, 16'h0005);
        chk("add_ctl", {out_alu_op, out_wb, out_rd}, {2'b00, 1'b1, 3'd3});

        cyc();
        send(W_LDI_2);
        @(negedge clk);
        chk("ldi_first_nobundle", out_valid, 0);
        cyc();
        send(16'hBEEF);
        @(negedge clk);
        chk("ldi_valid", out_valid, 1);
        chk("ldi_imm", out_imm, 16'hBEEF);
        chk("ldi_ctl", {out_use_imm, out_wb, out_alu_op, out_rd}, {1'b1, 1'b1, 2'b00, 3'd2});

        cyc();
        in_valid = 1; in_instr = W_LD_5_3;
        @(negedge clk);
        chk("ld_accept_ready", in_ready, 1);
        cyc();
        in_instr = W_SUB_5_4;
        @(negedge clk);
        chk("ld_bundle", {out_valid, out_mem_read, out_wb, out_rd}, {1'b1, 1'b1, 1'b1, 3'd5});
        chk("ld_addr", out_op1, 16'h0012);
        cyc();
        in_valid = 0;
        @(negedge clk);
        chk("bubble", {out_valid, in_ready}, 2'b00);
        cyc();
        @(negedge clk);
        chk("sub_after_bubble", {out_valid, out_alu_op, out_rd}, {1'b1, 2'b01, 3'd5});
        chk("sub_ops", {out_op1, out_op2}, {16'h0000, 16'h0005});

        cyc();
        send(W_AND_1_2);
        out_ready = 0;
        in_valid = 1; in_instr = W_OR_1_2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold", {out_valid, out_alu_op, out_rd, in_ready}, {1'b1, 2'b10, 3'd1, 1'b0});
            cyc();
        end
        out_ready = 1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        cyc();
        in_valid = 0;
        @(negedge clk);
        chk("bp_next", {out_valid, out_alu_op}, {1'b1, 2'b11});

        cyc();
        in_valid = 1; in_instr = W_OR_1_2;
        wb_en = 1; wb_addr = 1; wb_data = 16'h00AA;
        cyc();
        in_valid = 0; wb_en = 0;
        @(negedge clk);
`ifdef DECODE_BYPASS_EN
        chk("wb_same_cycle_op1", out_op1, 16'h00AA);
`else
        chk("wb_same_cycle_op1", out_op1, 16'h0000);
`endif

        cyc();
        send(W_LDI_2);
        reset = 0;
        @(negedge clk);
        chk("imm_reset_outs", {out_valid, in_ready, out_use_imm, out_imm}, 0);
        cyc();
        reset = 1;
        send(W_ADD_3_4);
        @(negedge clk);
        chk("post_reset_add", {out_valid, out_use_imm, out_wb, out_alu_op, out_rd},
                              {1'b1, 1'b0, 1'b1, 2'b00, 3'd3});
        chk("post_reset_ops", {out_op1, out_op2, out_imm}, 0);

        for (int c = 0; c < 3000; c++) begin
            cyc();
            in_valid  = ($urandom_range(3, 0) != 0);
            in_instr  = 16'($urandom);
            out_ready = ($urandom_range(3, 0) != 0);
            wb_en     = ($urandom_range(2, 0) == 0);
            wb_addr   = 3'($urandom);
            wb_data   = 16'($urandom);
            reset     = ($urandom_range(299, 0) != 0);
        end
        cyc();
        reset = 1; in_valid = 0; wb_en = 0;
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
